// File: rtl/trig_ctrl_pkg.sv
// trig_ctrl_pkg: shared state codes, default widths and multiplicity-width helper
//   no ports; imported by the interface, the popcount and the controller
package trig_ctrl_pkg;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_WINDOW  = 3'd1;
   localparam state_t ST_EVAL    = 3'd2;
   localparam state_t ST_FIRE    = 3'd3;
   localparam state_t ST_HOLDOFF = 3'd4;
   localparam int NCH_D = 4;
   localparam int WW_D  = 8;
   localparam int HW_D  = 16;
   localparam int PW_D  = 8;
   localparam int CW_D  = 16;
   function automatic int mult_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/trig_coincidence_ctrl_if.sv
// trig_coincidence_ctrl_if: hit/config inputs and trigger outputs of the coincidence controller
//   master: drives arm, pulse_in, enable_mask, window_len, min_mult, prescale, holdoff_len
//   slave : drives trig_out, trig_pattern, trig_count, busy
interface trig_coincidence_ctrl_if
   import trig_ctrl_pkg::*;
#(
   parameter int NCH = NCH_D,
   parameter int WW  = WW_D,
   parameter int HW  = HW_D,
   parameter int PW  = PW_D,
   parameter int CW  = CW_D,
   parameter int MW  = mult_w(NCH)
);
   logic           arm;
   logic [NCH-1:0] pulse_in;
   logic [NCH-1:0] enable_mask;
   logic [WW-1:0]  window_len;
   logic [MW-1:0]  min_mult;
   logic [PW-1:0]  prescale;
   logic [HW-1:0]  holdoff_len;
   logic           trig_out;
   logic [NCH-1:0] trig_pattern;
   logic [CW-1:0]  trig_count;
   logic           busy;
   modport master (
      output arm, pulse_in, enable_mask, window_len, min_mult, prescale, holdoff_len,
      input  trig_out, trig_pattern, trig_count, busy
   );
   modport slave (
      input  arm, pulse_in, enable_mask, window_len, min_mult, prescale, holdoff_len,
      output trig_out, trig_pattern, trig_count, busy
   );
endinterface

// File: rtl/trig_popcount.sv
// trig_popcount: combinational population count of an NCH-bit vector
//   vec: input bits; cnt: number of ones
module trig_popcount
   import trig_ctrl_pkg::*;
#(
   parameter int NCH = NCH_D,
   parameter int MW  = mult_w(NCH)
) (
   input  logic [NCH-1:0] vec,
   output logic [MW-1:0]  cnt
);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < NCH; i++) cnt = cnt + MW'(vec[i]);
   end
endmodule

// File: rtl/trig_coincidence_ctrl.sv
// trig_coincidence_ctrl: coincidence window, multiplicity check, prescaler, trigger and holdoff sequencing
//   clk, reset (async, active-high); bus: slave side of trig_coincidence_ctrl_if
module trig_coincidence_ctrl
   import trig_ctrl_pkg::*;
#(
   parameter int NCH = NCH_D,
   parameter int WW  = WW_D,
   parameter int HW  = HW_D,
   parameter int PW  = PW_D,
   parameter int CW  = CW_D,
   parameter int MW  = mult_w(NCH)
) (
   input logic                    clk,
   input logic                    reset,
   trig_coincidence_ctrl_if.slave bus
);
   state_t         state, nxt_state;
   logic [NCH-1:0] hit, hit_reg, nxt_hit_reg, nxt_pattern;
   logic [WW-1:0]  win_cnt, nxt_win_cnt, win_sh, nxt_win_sh, eff_win;
   logic [WW:0]    win_inc;
   logic [MW-1:0]  min_sh, nxt_min_sh, eff_min, mult;
   logic [PW-1:0]  presc_cnt, nxt_presc_cnt, presc_sh, nxt_presc_sh;
   logic [HW-1:0]  hold_cnt, nxt_hold_cnt, hold_sh, nxt_hold_sh;
   logic [CW-1:0]  nxt_count;
   logic           nxt_trig;

   assign hit     = bus.pulse_in & bus.enable_mask;
   assign eff_win = (win_sh == '0) ? WW'(1) : win_sh;
   assign eff_min = (min_sh == '0) ? MW'(1) : min_sh;
   // one bit wider so a window of all-ones length cannot wrap before the compare
   assign win_inc = {1'b0, win_cnt} + (WW+1)'(1);

   trig_popcount #(.NCH(NCH), .MW(MW)) u_pop (.vec(hit_reg), .cnt(mult));

   always_comb begin
      nxt_state     = state;
      nxt_hit_reg   = hit_reg;
      nxt_win_cnt   = win_cnt;
      nxt_presc_cnt = presc_cnt;
      nxt_hold_cnt  = hold_cnt;
      nxt_win_sh    = win_sh;
      nxt_min_sh    = min_sh;
      nxt_presc_sh  = presc_sh;
      nxt_hold_sh   = hold_sh;
      nxt_trig      = 1'b0;
      nxt_pattern   = bus.trig_pattern;
      nxt_count     = bus.trig_count;
      if (!bus.arm && state != ST_IDLE) begin
         nxt_state   = ST_IDLE;
         nxt_hit_reg = '0;
      end else begin
         case (state)
            ST_IDLE: if (bus.arm && hit != '0) begin
               nxt_hit_reg  = hit;
               nxt_win_cnt  = WW'(1);
               nxt_win_sh   = bus.window_len;
               nxt_min_sh   = bus.min_mult;
               nxt_presc_sh = bus.prescale;
               nxt_hold_sh  = bus.holdoff_len;
               nxt_state    = (bus.window_len <= WW'(1)) ? ST_EVAL : ST_WINDOW;
            end
            ST_WINDOW: begin
               nxt_hit_reg = hit_reg | hit;
               nxt_win_cnt = win_inc[WW-1:0];
               nxt_state   = (win_inc == {1'b0, eff_win}) ? ST_EVAL : ST_WINDOW;
            end
            ST_EVAL: begin
               nxt_state = ST_IDLE;
               if (mult >= eff_min && presc_cnt == presc_sh) begin
                  nxt_presc_cnt = '0;
                  nxt_trig      = 1'b1;
                  nxt_pattern   = hit_reg;
                  nxt_count     = (&bus.trig_count) ? bus.trig_count : bus.trig_count + CW'(1);
                  nxt_state     = ST_FIRE;
               end else if (mult >= eff_min) nxt_presc_cnt = presc_cnt + PW'(1);
            end
            ST_FIRE: begin
               nxt_hold_cnt = hold_sh;
               nxt_state    = (hold_sh == '0) ? ST_IDLE : ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
               nxt_hold_cnt = hold_cnt - HW'(1);
               nxt_state    = (hold_cnt == HW'(1)) ? ST_IDLE : ST_HOLDOFF;
            end
            default: nxt_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         hit_reg          <= '0;
         win_cnt          <= '0;
         presc_cnt        <= '0;
         hold_cnt         <= '0;
         win_sh           <= '0;
         min_sh           <= '0;
         presc_sh         <= '0;
         hold_sh          <= '0;
         bus.trig_out     <= 1'b0;
         bus.trig_pattern <= '0;
         bus.trig_count   <= '0;
         bus.busy         <= 1'b0;
      end else begin
         state            <= nxt_state;
         hit_reg          <= nxt_hit_reg;
         win_cnt          <= nxt_win_cnt;
         presc_cnt        <= nxt_presc_cnt;
         hold_cnt         <= nxt_hold_cnt;
         win_sh           <= nxt_win_sh;
         min_sh           <= nxt_min_sh;
         presc_sh         <= nxt_presc_sh;
         hold_sh          <= nxt_hold_sh;
         bus.trig_out     <= nxt_trig;
         bus.trig_pattern <= nxt_pattern;
         bus.trig_count   <= nxt_count;
         bus.busy         <= (nxt_state != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_trig_coincidence_ctrl.sv
// tb_trig_coincidence_ctrl: directed and randomized checks against a schedule-based reference model
module tb_trig_coincidence_ctrl;
   logic clk;
   logic reset;
   int   total = 0;
   int   bad = 0;

   trig_coincidence_ctrl_if #(.NCH(4), .WW(8), .HW(16), .PW(8), .CW(16)) ifc ();
   trig_coincidence_ctrl_if #(.NCH(4), .WW(8), .HW(16), .PW(8), .CW(2))  ifc2 ();

   assign ifc2.arm         = ifc.arm;
   assign ifc2.pulse_in    = ifc.pulse_in;
   assign ifc2.enable_mask = ifc.enable_mask;
   assign ifc2.window_len  = ifc.window_len;
   assign ifc2.min_mult    = ifc.min_mult;
   assign ifc2.prescale    = ifc.prescale;
   assign ifc2.holdoff_len = ifc.holdoff_len;

   trig_coincidence_ctrl #(.NCH(4), .WW(8), .HW(16), .PW(8), .CW(16)) dut (
      .clk(clk), .reset(reset), .bus(ifc)
   );
   trig_coincidence_ctrl #(.NCH(4), .WW(8), .HW(16), .PW(8), .CW(2)) dut2 (
      .clk(clk), .reset(reset), .bus(ifc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a window opened at edge k is evaluated at edge k+eff_window;
   // free_at is the first edge at which a new window may open again.
   int         k = 0;
   int         free_at = 0;
   int         t_eval = 0;
   logic [3:0] acc = '0;
   logic [3:0] h;
   int         s_win, s_min, s_hold;
   logic [7:0] s_presc = '0;
   logic [7:0] m_presc = '0;
   logic       m_trig = 1'b0;
   logic       m_busy = 1'b0;
   logic [3:0] m_pat = '0;
   int         m_cnt = 0;
   int         m_cnt2 = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         free_at = 0;
         m_trig  = 1'b0;
         m_busy  = 1'b0;
         m_pat   = '0;
         m_cnt   = 0;
         m_cnt2  = 0;
         m_presc = '0;
      end else begin
         m_trig = 1'b0;
         h = ifc.pulse_in & ifc.enable_mask;
         if (k >= free_at) begin
            if (ifc.arm && h != 0) begin
               s_win   = (ifc.window_len == 0) ? 1 : int'(ifc.window_len);
               s_min   = (ifc.min_mult == 0) ? 1 : int'(ifc.min_mult);
               s_presc = ifc.prescale;
               s_hold  = int'(ifc.holdoff_len);
               acc     = h;
               t_eval  = k + s_win;
               free_at = t_eval + 1;
            end
         end else if (!ifc.arm) begin
            free_at = k + 1;
         end else if (k < t_eval) begin
            acc = acc | h;
         end else if (k == t_eval) begin
            free_at = k + 1;
            if ($countones(acc) >= s_min) begin
               if (m_presc == s_presc) begin
                  m_trig  = 1'b1;
                  m_pat   = acc;
                  m_cnt   = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                  m_cnt2  = (m_cnt2 == 3) ? m_cnt2 : m_cnt2 + 1;
                  m_presc = '0;
                  free_at = k + 2 + s_hold;
               end else m_presc = m_presc + 8'd1;
            end
         end
         m_busy = (k + 1 < free_at);
         k++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compares both DUTs against the model every cycle, then moves to just after the next edge
   task automatic step();
      @(negedge clk);
      chk("trig_out", 32'(ifc.trig_out), 32'(m_trig));
      chk("trig_pattern", 32'(ifc.trig_pattern), 32'(m_pat));
      chk("trig_count", 32'(ifc.trig_count), 32'(m_cnt));
      chk("busy", 32'(ifc.busy), 32'(m_busy));
      chk("sat_trig_out", 32'(ifc2.trig_out), 32'(m_trig));
      chk("sat_count", 32'(ifc2.trig_count), 32'(m_cnt2));
      @(posedge clk);
      #2;
   endtask

   int fires;

   initial begin
      reset = 1'b1;
      ifc.arm = 1'b1;
      ifc.pulse_in = '0;
      ifc.enable_mask = 4'hF;
      ifc.window_len = 8'd1;
      ifc.min_mult = 3'd1;
      ifc.prescale = 8'd0;
      ifc.holdoff_len = 16'd0;
      step();
      step();
      reset = 1'b0;
      chk("rst_trig", 32'(ifc.trig_out), 0);
      chk("rst_count", 32'(ifc.trig_count), 0);
      chk("rst_busy", 32'(ifc.busy), 0);
      chk("rst_pat", 32'(ifc.trig_pattern), 0);
      step();

      // single hit, window 1
      ifc.pulse_in = 4'b0010;
      step();
      ifc.pulse_in = '0;
      chk("t1_busy", 32'(ifc.busy), 1);
      chk("t1_early", 32'(ifc.trig_out), 0);
      step();
      chk("t1_trig", 32'(ifc.trig_out), 1);
      chk("t1_pat", 32'(ifc.trig_pattern), 4'b0010);
      chk("t1_cnt", 32'(ifc.trig_count), 1);
      step();
      chk("t1_drop", 32'(ifc.trig_out), 0);
      chk("t1_idle", 32'(ifc.busy), 0);
      step();

      // coincidence in a 4-cycle window
      ifc.window_len = 8'd4;
      ifc.min_mult = 3'd2;
      ifc.pulse_in = 4'b0001;
      step();
      ifc.pulse_in = '0;
      step();
      step();
      ifc.pulse_in = 4'b0100;
      step();
      ifc.pulse_in = '0;
      chk("t2_early", 32'(ifc.trig_out), 0);
      step();
      chk("t2_trig", 32'(ifc.trig_out), 1);
      chk("t2_pat", 32'(ifc.trig_pattern), 4'b0101);
      chk("t2_cnt", 32'(ifc.trig_count), 2);
      step();
      step();
      ifc.pulse_in = 4'b0001;
      step();
      ifc.pulse_in = '0;
      repeat (3) step();
      ifc.pulse_in = 4'b0100;
      step();
      ifc.pulse_in = '0;
      chk("t2b_idle", 32'(ifc.busy), 0);
      step();
      chk("t2b_notrig", 32'(ifc.trig_out), 0);
      chk("t2b_cnt", 32'(ifc.trig_count), 2);

      // prescale 2
      ifc.window_len = 8'd1;
      ifc.min_mult = 3'd1;
      ifc.prescale = 8'd2;
      fires = 0;
      for (int i = 1; i <= 9; i++) begin
         ifc.pulse_in = 4'b0001;
         step();
         ifc.pulse_in = '0;
         step();
         fires += int'(ifc.trig_out);
         if (i == 3 || i == 6 || i == 9) chk("t3_fire", 32'(ifc.trig_out), 1);
         step();
         step();
         if (i == 7) begin
            chk("t3_fires7", 32'(fires), 2);
            chk("t3_cnt7", 32'(ifc.trig_count), 4);
         end
      end
      chk("t3_cnt9", 32'(ifc.trig_count), 5);
      ifc.prescale = 8'd0;

      // holdoff 10
      ifc.holdoff_len = 16'd10;
      ifc.pulse_in = 4'b0001;
      step();
      ifc.pulse_in = '0;
      step();
      chk("t4_trig", 32'(ifc.trig_out), 1);
      for (int i = 1; i <= 10; i++) begin
         if (i == 5) ifc.pulse_in = 4'b0001;
         step();
         ifc.pulse_in = '0;
         chk("t4_busy", 32'(ifc.busy), 1);
         chk("t4_quiet", 32'(ifc.trig_out), 0);
      end
      step();
      chk("t4_free", 32'(ifc.busy), 0);
      ifc.pulse_in = 4'b0001;
      step();
      ifc.pulse_in = '0;
      chk("t4_reopen", 32'(ifc.busy), 1);
      step();
      chk("t4_trig2", 32'(ifc.trig_out), 1);
      chk("t4_cnt", 32'(ifc.trig_count), 7);
      repeat (12) step();
      chk("t4_end", 32'(ifc.busy), 0);
      ifc.holdoff_len = 16'd0;

      // masked channel, then arm dropped mid-window
      ifc.enable_mask = 4'b1110;
      ifc.pulse_in = 4'b0001;
      step();
      ifc.pulse_in = '0;
      chk("t5_masked", 32'(ifc.busy), 0);
      ifc.enable_mask = 4'hF;
      ifc.window_len = 8'd6;
      ifc.pulse_in = 4'b0011;
      step();
      ifc.pulse_in = '0;
      chk("t5_open", 32'(ifc.busy), 1);
      step();
      ifc.arm = 1'b0;
      step();
      chk("t5_armdrop", 32'(ifc.busy), 0);
      ifc.arm = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("t5_notrig", 32'(ifc.trig_out), 0);
      end
      chk("t5_cnt", 32'(ifc.trig_count), 7);
      ifc.window_len = 8'd1;

      // async reset in the trig_out cycle and during holdoff
      ifc.holdoff_len = 16'd10;
      ifc.pulse_in = 4'b1000;
      step();
      ifc.pulse_in = '0;
      step();
      chk("t6_trig", 32'(ifc.trig_out), 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_trig", 32'(ifc.trig_out), 0);
      chk("t6_rst_cnt", 32'(ifc.trig_count), 0);
      chk("t6_rst_pat", 32'(ifc.trig_pattern), 0);
      chk("t6_rst_busy", 32'(ifc.busy), 0);
      step();
      reset = 1'b0;
      step();
      ifc.pulse_in = 4'b1000;
      step();
      ifc.pulse_in = '0;
      repeat (3) step();
      chk("t6_hold", 32'(ifc.busy), 1);
      reset = 1'b1;
      #1;
      chk("t6_rst2_busy", 32'(ifc.busy), 0);
      chk("t6_rst2_cnt", 32'(ifc.trig_count), 0);
      chk("t6_rst2_pat", 32'(ifc.trig_pattern), 0);
      step();
      reset = 1'b0;
      ifc.holdoff_len = 16'd0;
      step();

      // saturation on the narrow-counter instance
      for (int i = 1; i <= 5; i++) begin
         ifc.pulse_in = 4'b0100;
         step();
         ifc.pulse_in = '0;
         repeat (3) step();
         if (i == 4) chk("t7_sat4", 32'(ifc2.trig_count), 3);
      end
      chk("t7_sat5", 32'(ifc2.trig_count), 3);
      chk("t7_cnt", 32'(ifc.trig_count), 5);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            ifc.window_len  = 8'($urandom_range(0, 6));
            ifc.min_mult    = 3'($urandom_range(0, 4));
            ifc.prescale    = 8'($urandom_range(0, 3));
            ifc.holdoff_len = 16'($urandom_range(0, 8));
            ifc.enable_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         end
         ifc.arm = ($urandom_range(0, 30) != 0);
         ifc.pulse_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         if ($urandom_range(0, 500) == 0) begin
            reset = 1'b1;
            #1;
            step();
            reset = 1'b0;
         end
         step();
      end
      ifc.pulse_in = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
